card_game_ctrl: RTL and testbench

- Sequencing controller for the two-player card-draw datapath: random generator, card value decode and per-player routing.
- Decodes keypad events and grants the shared random source to the player whose turn it is.
- Pulses the generator enable, waits out its latency, then decodes and captures the card.
- Accumulates per-player scores, alternates turns, and detects bust/stand/end-of-game with a winner.

---
 rtl/card_game_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_card_game_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_game_ctrl.sv
// card_game_ctrl: sequencing controller for the two-player card-draw game.
// Turns keypad presses into draw/stand/start actions, requests a card from the
// shared random generator, decodes it, keeps both scores and picks a winner.
module card_game_ctrl #(
   parameter logic [3:0]  KEY_START = 4'b1010,
   parameter logic [3:0]  KEY_DRAW  = 4'b0011,
   parameter logic [3:0]  KEY_STAND = 4'b0001,
   parameter int unsigned RND_LAT   = 2,
   parameter int unsigned LIMIT     = 21,
   parameter int unsigned MAX_CARDS = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] keypad_in,
   input  logic [4:0] rnd,
   output logic       rnd_en,
   output logic       whose,
   output logic       card_valid,
   output logic       card_owner,
   output logic [1:0] color,
   output logic [2:0] number,
   output logic [5:0] p1_score,
   output logic [5:0] p2_score,
   output logic       finish,
   output logic [1:0] winner,
   output logic       busy
);

   localparam int unsigned SCORE_W = 6;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned LAT_W   = 3;
   localparam logic [SCORE_W-1:0] LIMIT_V = SCORE_W'(LIMIT);
   localparam logic [CNT_W-1:0]   MAX_V   = CNT_W'(MAX_CARDS);
   localparam logic [LAT_W-1:0]   LAT_V   = LAT_W'(RND_LAT);

   typedef enum logic [2:0] {
      S_IDLE, S_TURN, S_REQ, S_WAIT, S_CAPTURE, S_CHECK, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         key_prev;
   logic [LAT_W-1:0]   wait_cnt;
   logic [1:0]         stand;
   logic [SCORE_W-1:0] score [2];
   logic [CNT_W-1:0]   cards [2];

   logic               key_ev, ev_start, ev_draw, ev_stand;
   logic               opp_stood, bust, max_hit, both_stood;
   logic [1:0]         cmp_winner, bust_winner;
   logic [1:0]         dec_color;
   logic [2:0]         dec_number;
   logic               do_start, do_stand, do_capture, do_check;

   assign p1_score = score[0];
   assign p2_score = score[1];

   // Key edge detection, card decode and game-rule decodes for the current player
   always_comb begin
      key_ev      = (keypad_in != 4'b0000) && (key_prev == 4'b0000);
      ev_start    = key_ev && (keypad_in == KEY_START);
      ev_draw     = key_ev && (keypad_in == KEY_DRAW);
      ev_stand    = key_ev && (keypad_in == KEY_STAND);
      opp_stood   = stand[~whose];
      bust        = score[whose] > LIMIT_V;
      max_hit     = cards[whose] == MAX_V;
      both_stood  = opp_stood && (stand[whose] || max_hit);
      bust_winner = whose ? 2'b01 : 2'b10;
      if (score[0] > score[1])      cmp_winner = 2'b01;
      else if (score[1] > score[0]) cmp_winner = 2'b10;
      else                          cmp_winner = 2'b11;
      unique case (rnd[4:3])
         2'b00:   dec_color = 2'b01;
         2'b01:   dec_color = 2'b10;
         2'b10:   dec_color = 2'b11;
         default: dec_color = 2'b01;
      endcase
      if (rnd[2:0] < 3'd5) dec_number = rnd[2:0] + 3'd1;
      else                 dec_number = rnd[2:0] - 3'd4;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (ev_start) state_d = S_TURN;
         S_TURN: begin
            if (ev_draw)                     state_d = S_REQ;
            else if (ev_stand && opp_stood)  state_d = S_DONE;
         end
         S_REQ:     state_d = (LAT_V <= LAT_W'(1)) ? S_CAPTURE : S_WAIT;
         S_WAIT:    if (wait_cnt <= LAT_W'(2)) state_d = S_CAPTURE;
         S_CAPTURE: state_d = S_CHECK;
         S_CHECK:   state_d = (bust || both_stood) ? S_DONE : S_TURN;
         S_DONE:    if (ev_start) state_d = S_TURN;
         default:   state_d = S_IDLE;
      endcase
   end

   // Control strobes derived from the current state
   always_comb begin
      do_start   = 1'b0;
      do_stand   = 1'b0;
      do_capture = 1'b0;
      do_check   = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: do_start   = ev_start;
         S_TURN:         do_stand   = ev_stand;
         S_CAPTURE:      do_capture = 1'b1;
         S_CHECK:        do_check   = 1'b1;
         default:        ;
      endcase
   end

   // Game datapath and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_prev   <= 4'b0000;
         wait_cnt   <= '0;
         stand      <= 2'b00;
         score[0]   <= '0;
         score[1]   <= '0;
         cards[0]   <= '0;
         cards[1]   <= '0;
         rnd_en     <= 1'b0;
         whose      <= 1'b0;
         card_valid <= 1'b0;
         card_owner <= 1'b0;
         color      <= 2'b00;
         number     <= 3'b000;
         finish     <= 1'b0;
         winner     <= 2'b00;
         busy       <= 1'b0;
      end else begin
         key_prev   <= keypad_in;
         rnd_en     <= (state_d == S_REQ);
         busy       <= state_d inside {S_TURN, S_REQ, S_WAIT, S_CAPTURE, S_CHECK};
         finish     <= (state_d == S_DONE) && (state_q != S_DONE);
         card_valid <= do_capture;

         if (state_q == S_REQ)       wait_cnt <= LAT_V;
         else if (state_q == S_WAIT) wait_cnt <= wait_cnt - LAT_W'(1);

         if (do_start) begin
            score[0] <= '0;
            score[1] <= '0;
            cards[0] <= '0;
            cards[1] <= '0;
            stand    <= 2'b00;
            winner   <= 2'b00;
            whose    <= 1'b0;
         end

         if (do_stand) begin
            stand[whose] <= 1'b1;
            if (opp_stood) winner <= cmp_winner;
            else           whose  <= ~whose;
         end

         if (do_capture) begin
            color        <= dec_color;
            number       <= dec_number;
            card_owner   <= whose;
            score[whose] <= score[whose] + SCORE_W'(dec_number);
            cards[whose] <= cards[whose] + CNT_W'(1);
         end

         // A bust ends the game outright; otherwise a full hand forces a stand
         if (do_check) begin
            if (bust) begin
               winner <= bust_winner;
            end else begin
               if (max_hit) stand[whose] <= 1'b1;
               if (both_stood)      winner <= cmp_winner;
               else if (!opp_stood) whose  <= ~whose;
            end
         end
      end
   end

endmodule

// File: tb/tb_card_game_ctrl.sv
// Bench for card_game_ctrl: keypad actions against a game-rule reference model.
module tb_card_game_ctrl;

   localparam logic [3:0] K_START = 4'b1010;
   localparam logic [3:0] K_DRAW  = 4'b0011;
   localparam logic [3:0] K_STAND = 4'b0001;
   localparam int RLAT = 2;
   localparam int LIM  = 21;
   localparam int MAXC = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] keypad_in = 4'b0000;
   logic [4:0] rnd = 5'b00000;
   logic       rnd_en, whose, card_valid, card_owner, finish, busy;
   logic [1:0] color, winner;
   logic [2:0] number;
   logic [5:0] p1_score, p2_score;
   logic [15:0] dut_vec;

   card_game_ctrl #(
      .KEY_START(K_START), .KEY_DRAW(K_DRAW), .KEY_STAND(K_STAND),
      .RND_LAT(RLAT), .LIMIT(LIM), .MAX_CARDS(MAXC)
   ) dut (
      .clk(clk), .rst(rst), .keypad_in(keypad_in), .rnd(rnd),
      .rnd_en(rnd_en), .whose(whose), .card_valid(card_valid),
      .card_owner(card_owner), .color(color), .number(number),
      .p1_score(p1_score), .p2_score(p2_score), .finish(finish),
      .winner(winner), .busy(busy)
   );

   always #5 clk = ~clk;

   assign dut_vec = {whose, p1_score, p2_score, winner, busy};

   int n_cmp = 0;
   int n_bad = 0;

   // Reference game record
   bit         m_in_game;
   bit         m_whose;
   int         m_score [2];
   int         m_cards [2];
   bit         m_stood [2];
   logic [1:0] m_winner;

   // Observations from the last key press window
   logic [4:0] card_val;
   int         n_en, n_valid, n_fin, en_cyc, valid_cyc;
   logic [1:0] v_color;
   logic [2:0] v_number;
   logic       v_owner;

   logic [3:0] junk_codes [6] = '{4'd2, 4'd4, 4'd5, 4'd7, 4'd12, 4'd15};

   function automatic logic [1:0] rank(int a, int b);
      if (a > b) return 2'b01;
      if (b > a) return 2'b10;
      return 2'b11;
   endfunction

   function automatic logic [15:0] model_vec();
      return {m_whose, 6'(m_score[0]), 6'(m_score[1]), m_winner, m_in_game};
   endfunction

   task automatic model_reset();
      m_in_game = 1'b0;
      m_whose   = 1'b0;
      m_winner  = 2'b00;
      for (int p = 0; p < 2; p++) begin
         m_score[p] = 0;
         m_cards[p] = 0;
         m_stood[p] = 1'b0;
      end
   endtask

   // Press a key for 'hold' cycles; act as the generator: the requested card is
   // valid only on the cycle RLAT after the request, a different card otherwise.
   task automatic press_key(input logic [3:0] key, input int hold, input int window);
      n_en = 0; n_valid = 0; n_fin = 0; en_cyc = -1; valid_cyc = -1;
      for (int i = 0; i < window; i++) begin
         @(negedge clk);
         if (rnd_en === 1'b1) begin n_en++; en_cyc = i; end
         if (card_valid === 1'b1) begin
            n_valid++; valid_cyc = i;
            v_color = color; v_number = number; v_owner = card_owner;
         end
         if (finish === 1'b1) n_fin++;
         if (i == 0)         keypad_in = key;
         else if (i == hold) keypad_in = 4'b0000;
         if (en_cyc >= 0 && i == en_cyc + RLAT) rnd = card_val;
         else                                   rnd = card_val ^ 5'b01100;
      end
   endtask

   task automatic do_draw(input logic [4:0] v, input int hold);
      int         w, num, exp_cards, exp_fin;
      logic [1:0] ecol;
      logic       eowner;
      card_val  = v;
      num       = (int'(v[2:0]) % 5) + 1;
      ecol      = 2'((int'(v[4:3]) % 3) + 1);
      eowner    = m_whose;
      exp_cards = m_in_game ? 1 : 0;
      exp_fin   = 0;
      if (m_in_game) begin
         w = int'(m_whose);
         m_score[w] += num;
         m_cards[w]++;
         if (m_score[w] > LIM) begin
            m_winner = m_whose ? 2'b01 : 2'b10;
            m_in_game = 1'b0; exp_fin = 1;
         end else begin
            if (m_cards[w] == MAXC) m_stood[w] = 1'b1;
            if (m_stood[0] && m_stood[1]) begin
               m_winner = rank(m_score[0], m_score[1]);
               m_in_game = 1'b0; exp_fin = 1;
            end else if (!m_stood[1-w]) begin
               m_whose = ~m_whose;
            end
         end
      end
      press_key(K_DRAW, hold, 16);
      n_cmp++; if (n_en !== exp_cards) begin n_bad++;
         $display("FAIL draw_rnd_en_pulses: got %0d expected %0d", n_en, exp_cards); end
      n_cmp++; if (n_valid !== exp_cards) begin n_bad++;
         $display("FAIL draw_card_valid_pulses: got %0d expected %0d", n_valid, exp_cards); end
      if (exp_cards == 1 && n_valid == 1 && n_en == 1) begin
         n_cmp++; if (valid_cyc - en_cyc !== RLAT + 1) begin n_bad++;
            $display("FAIL draw_latency: got %0d expected %0d", valid_cyc - en_cyc, RLAT + 1); end
         n_cmp++; if ({v_owner, v_color, v_number} !== {eowner, ecol, 3'(num)}) begin n_bad++;
            $display("FAIL draw_card rnd=%b: got owner=%0d color=%b number=%0d expected owner=%0d color=%b number=%0d",
                     v, v_owner, v_color, v_number, eowner, ecol, num); end
      end
      n_cmp++; if (n_fin !== exp_fin) begin n_bad++;
         $display("FAIL draw_finish_pulses: got %0d expected %0d", n_fin, exp_fin); end
      n_cmp++; if (dut_vec !== model_vec()) begin n_bad++;
         $display("FAIL draw_state {whose,p1,p2,winner,busy}: got %h expected %h", dut_vec, model_vec()); end
   endtask

   task automatic do_stand(input int hold);
      int w, exp_fin;
      exp_fin = 0;
      if (m_in_game) begin
         w = int'(m_whose);
         m_stood[w] = 1'b1;
         if (m_stood[1-w]) begin
            m_winner = rank(m_score[0], m_score[1]);
            m_in_game = 1'b0; exp_fin = 1;
         end else begin
            m_whose = ~m_whose;
         end
      end
      press_key(K_STAND, hold, 8);
      n_cmp++; if (n_en !== 0) begin n_bad++;
         $display("FAIL stand_rnd_en_pulses: got %0d expected 0", n_en); end
      n_cmp++; if (n_fin !== exp_fin) begin n_bad++;
         $display("FAIL stand_finish_pulses: got %0d expected %0d", n_fin, exp_fin); end
      n_cmp++; if (dut_vec !== model_vec()) begin n_bad++;
         $display("FAIL stand_state {whose,p1,p2,winner,busy}: got %h expected %h", dut_vec, model_vec()); end
   endtask

   task automatic do_start(input int hold);
      if (!m_in_game) begin
         model_reset();
         m_in_game = 1'b1;
      end
      press_key(K_START, hold, 8);
      n_cmp++; if (n_en !== 0 || n_fin !== 0) begin n_bad++;
         $display("FAIL start_pulses: got rnd_en=%0d finish=%0d expected 0 0", n_en, n_fin); end
      n_cmp++; if (dut_vec !== model_vec()) begin n_bad++;
         $display("FAIL start_state {whose,p1,p2,winner,busy}: got %h expected %h", dut_vec, model_vec()); end
   endtask

   task automatic do_junk();
      press_key(junk_codes[$urandom_range(0, 5)], $urandom_range(1, 3), 8);
      n_cmp++; if (n_en !== 0 || n_fin !== 0) begin n_bad++;
         $display("FAIL junk_pulses: got rnd_en=%0d finish=%0d expected 0 0", n_en, n_fin); end
      n_cmp++; if (dut_vec !== model_vec()) begin n_bad++;
         $display("FAIL junk_state {whose,p1,p2,winner,busy}: got %h expected %h", dut_vec, model_vec()); end
   endtask

   task automatic test_reset();
      model_reset();
      n_cmp++; if ({rnd_en, whose, card_valid, card_owner, color, number, p1_score,
                   p2_score, finish, winner, busy} !== 25'd0) begin n_bad++;
         $display("FAIL reset_outputs: got nonzero outputs, expected all zero"); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (dut_vec !== model_vec()) begin n_bad++;
         $display("FAIL reset_idle_state: got %h expected %h", dut_vec, model_vec()); end
   endtask

   task automatic test_idle_ignore();
      do_draw(5'b00011, 2);
      do_stand(1);
      do_junk();
   endtask

   task automatic test_first_draw();
      do_start(1);
      do_draw(5'b11000, 1);
      n_cmp++; if ({p1_score, whose} !== {6'd1, 1'b1}) begin n_bad++;
         $display("FAIL first_draw: got p1=%0d whose=%0d expected p1=1 whose=1", p1_score, whose); end
   endtask

   task automatic test_alternation();
      do_draw(5'b10001, 9);
      n_cmp++; if ({p2_score, whose, color, number} !== {6'd2, 1'b0, 2'b11, 3'd2}) begin n_bad++;
         $display("FAIL alternation: got p2=%0d whose=%0d color=%b number=%0d expected 2 0 11 2",
                  p2_score, whose, color, number); end
   endtask

   task automatic test_stand_stand();
      do_stand(1);
      do_stand(3);
      n_cmp++; if (winner !== 2'b10) begin n_bad++;
         $display("FAIL stand_stand_winner: got %b expected 10", winner); end
   endtask

   task automatic test_tie();
      do_start(2);
      do_draw(5'b00001, 1);
      do_draw(5'b01110, 1);
      do_stand(1);
      do_stand(1);
      n_cmp++; if (winner !== 2'b11) begin n_bad++;
         $display("FAIL tie_winner: got %b expected 11", winner); end
   endtask

   task automatic test_bust();
      do_start(1);
      for (int k = 0; k < 4; k++) begin
         do_draw(5'b00100, 1);
         do_draw(5'b01000, 1);
      end
      do_draw(5'b10010, 1);
      n_cmp++; if ({winner, p1_score} !== {2'b10, 6'd23}) begin n_bad++;
         $display("FAIL bust: got winner=%b p1=%0d expected winner=10 p1=23", winner, p1_score); end
      do_draw(5'b00100, 1);
      do_stand(1);
      do_junk();
   endtask

   task automatic test_forced_stand();
      do_start(1);
      do_draw(5'b00000, 1);
      do_stand(1);
      for (int k = 0; k < MAXC - 1; k++) do_draw(5'b00101, 1);
      n_cmp++; if ({winner, p1_score} !== {2'b01, 6'(MAXC)}) begin n_bad++;
         $display("FAIL forced_stand: got winner=%b p1=%0d expected winner=01 p1=%0d", winner, p1_score, MAXC); end
   endtask

   task automatic test_reset_midwait();
      int guard;
      do_start(1);
      card_val = 5'b00010;
      @(negedge clk);
      keypad_in = K_DRAW;
      guard = 0;
      while (rnd_en !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
      n_cmp++; if (rnd_en !== 1'b1) begin n_bad++;
         $display("FAIL midwait_rnd_en_timeout: got %b expected 1", rnd_en); end
      @(negedge clk);
      keypad_in = 4'b0000;
      rst = 1'b1;
      #1;
      n_cmp++; if ({rnd_en, whose, card_valid, card_owner, color, number, p1_score,
                   p2_score, finish, winner, busy} !== 25'd0) begin n_bad++;
         $display("FAIL midwait_reset_outputs: got nonzero outputs, expected all zero"); end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (RLAT + 4) @(negedge clk);
      n_cmp++; if ({dut_vec, card_valid, rnd_en} !== {model_vec(), 2'b00}) begin n_bad++;
         $display("FAIL midwait_after_reset: got %h expected %h", {dut_vec, card_valid, rnd_en},
                  {model_vec(), 2'b00}); end
      do_start(1);
   endtask

   task automatic test_random_games();
      int r;
      for (int g = 0; g < 6; g++) begin
         do_start($urandom_range(1, 3));
         for (int a = 0; a < 40 && m_in_game; a++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      do_draw(5'($urandom), $urandom_range(1, 10));
            else if (r < 85) do_stand($urandom_range(1, 3));
            else if (r < 95) do_junk();
            else             do_start(1);
         end
         do_draw(5'($urandom), 1);
      end
   endtask

   initial begin
      model_reset();
      card_val = 5'b00000;
      repeat (3) @(negedge clk);
      test_reset();
      test_idle_ignore();
      test_first_draw();
      test_alternation();
      test_stand_stand();
      test_tie();
      test_bust();
      test_forced_stand();
      test_reset_midwait();
      test_random_games();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
